execute_cycle: RTL and testbench

- Execute stage of the 5-stage RV32I pipeline; the producer end of the fetch stage's redirect interface.
- Selects forwarded operands, runs the ALU and resolves branches/jumps.
- Drives PCSrcE/PCTargetE back to fetch_cycle combinationally in the same cycle.
- Registers results into the EX/MEM pipeline register for the memory stage.

---
 rtl/execute_cycle_if.sv | 47 ++++
 rtl/execute_cycle.sv | 91 +++++++++
 tb/tb_execute_cycle.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/execute_cycle_if.sv
// Execute-stage bus: ID/EX inputs, forwarding inputs, fetch redirect and EX/MEM outputs.
interface execute_cycle_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) ();
  logic              RegWriteE;
  logic              ALUSrcE;
  logic              MemWriteE;
  logic              ResultSrcE;
  logic              BranchE;
  logic              JumpE;
  logic [2:0]        ALUControlE;
  logic [DATA_W-1:0] RD1E;
  logic [DATA_W-1:0] RD2E;
  logic [DATA_W-1:0] ImmExtE;
  logic [DATA_W-1:0] PCE;
  logic [DATA_W-1:0] PCPlus4E;
  logic [REG_W-1:0]  RdE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic [DATA_W-1:0] ResultW;
  logic              PCSrcE;
  logic [DATA_W-1:0] PCTargetE;
  logic              RegWriteM;
  logic              MemWriteM;
  logic              ResultSrcM;
  logic [REG_W-1:0]  RdM;
  logic [DATA_W-1:0] ALUResultM;
  logic [DATA_W-1:0] WriteDataM;
  logic [DATA_W-1:0] PCPlus4M;

  // Driver side (decode/hazard/writeback stages and their consumers).
  modport master (
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUControlE,
           RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM,
           WriteDataM, PCPlus4M
  );

  // Execute stage side.
  modport slave (
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUControlE,
           RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM,
           WriteDataM, PCPlus4M
  );
endinterface

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution, EX/MEM register.
module execute_cycle #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic          clk,
  input  logic          rst,
  execute_cycle_if.slave bus
);

  logic [DATA_W-1:0] w_src_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_src_b;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_zero;

  logic              r_reg_write_m;
  logic              r_mem_write_m;
  logic              r_result_src_m;
  logic [REG_W-1:0]  r_rd_m;
  logic [DATA_W-1:0] r_alu_result_m;
  logic [DATA_W-1:0] r_write_data_m;
  logic [DATA_W-1:0] r_pc_plus4_m;

  // Forwarding muxes; the EX/MEM source is the registered result, so no comb loop.
  always_comb begin
    w_src_a = bus.RD1E;
    w_fwd_b = bus.RD2E;
    case (bus.ForwardAE)
      2'b01:   w_src_a = bus.ResultW;
      2'b10:   w_src_a = r_alu_result_m;
      default: w_src_a = bus.RD1E;
    endcase
    case (bus.ForwardBE)
      2'b01:   w_fwd_b = bus.ResultW;
      2'b10:   w_fwd_b = r_alu_result_m;
      default: w_fwd_b = bus.RD2E;
    endcase
    w_src_b = bus.ALUSrcE ? bus.ImmExtE : w_fwd_b;
  end

  // ALU; unused opcodes yield zero.
  always_comb begin
    w_alu_result = '0;
    case (bus.ALUControlE)
      3'b000:  w_alu_result = w_src_a + w_src_b;
      3'b001:  w_alu_result = w_src_a - w_src_b;
      3'b010:  w_alu_result = w_src_a & w_src_b;
      3'b011:  w_alu_result = w_src_a | w_src_b;
      3'b100:  w_alu_result = w_src_a ^ w_src_b;
      3'b101:  w_alu_result = {{(DATA_W-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
      default: w_alu_result = '0;
    endcase
  end

  assign w_zero = (w_alu_result == '0);

  // Redirect to fetch is combinational and deliberately not gated by reset.
  assign bus.PCSrcE    = (bus.BranchE & w_zero) | bus.JumpE;
  assign bus.PCTargetE = bus.PCE + bus.ImmExtE;

  // EX/MEM pipeline register, no stall; async reset flushes the in-flight instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= 1'b0;
      r_rd_m         <= '0;
      r_alu_result_m <= '0;
      r_write_data_m <= '0;
      r_pc_plus4_m   <= '0;
    end else begin
      r_reg_write_m  <= bus.RegWriteE;
      r_mem_write_m  <= bus.MemWriteE;
      r_result_src_m <= bus.ResultSrcE;
      r_rd_m         <= bus.RdE;
      r_alu_result_m <= w_alu_result;
      r_write_data_m <= w_fwd_b;
      r_pc_plus4_m   <= bus.PCPlus4E;
    end
  end

  assign bus.RegWriteM  = r_reg_write_m;
  assign bus.MemWriteM  = r_mem_write_m;
  assign bus.ResultSrcM = r_result_src_m;
  assign bus.RdM        = r_rd_m;
  assign bus.ALUResultM = r_alu_result_m;
  assign bus.WriteDataM = r_write_data_m;
  assign bus.PCPlus4M   = r_pc_plus4_m;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed plan plus randomized cycles vs. a reference model.
module tb_execute_cycle;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference copy of the EX/MEM register contents.
  logic              exp_reg_write, exp_mem_write, exp_result_src;
  logic [REG_W-1:0]  exp_rd;
  logic [DATA_W-1:0] exp_alu, exp_wd, exp_pc4;

  always #5 clk = ~clk;

  execute_cycle_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  execute_cycle #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0:    return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      3'd1:    return 32'((longint'(a) - longint'(b)) & 64'hFFFF_FFFF);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rd);
    if (sel == 2'd1) return bus.ResultW;
    if (sel == 2'd2) return exp_alu;
    return rd;
  endfunction

  task automatic clear_model();
    exp_reg_write  = 1'b0;
    exp_mem_write  = 1'b0;
    exp_result_src = 1'b0;
    exp_rd         = '0;
    exp_alu        = '0;
    exp_wd         = '0;
    exp_pc4        = '0;
  endtask

  task automatic check_m(input string tag);
    check({tag, "_regwrite"}, 32'(bus.RegWriteM), 32'(exp_reg_write));
    check({tag, "_memwrite"}, 32'(bus.MemWriteM), 32'(exp_mem_write));
    check({tag, "_resultsrc"}, 32'(bus.ResultSrcM), 32'(exp_result_src));
    check({tag, "_rd"}, 32'(bus.RdM), 32'(exp_rd));
    check({tag, "_alu"}, bus.ALUResultM, exp_alu);
    check({tag, "_wdata"}, bus.WriteDataM, exp_wd);
    check({tag, "_pc4"}, bus.PCPlus4M, exp_pc4);
  endtask

  task automatic set_idle();
    bus.RegWriteE = 0; bus.ALUSrcE = 0; bus.MemWriteE = 0; bus.ResultSrcE = 0;
    bus.BranchE = 0; bus.JumpE = 0; bus.ALUControlE = 0;
    bus.RD1E = 0; bus.RD2E = 0; bus.ImmExtE = 0; bus.PCE = 0; bus.PCPlus4E = 0;
    bus.RdE = 0; bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ResultW = 0;
  endtask

  // Check redirect with current inputs, clock once, then check the registered stage.
  task automatic cycle(input string tag);
    logic [31:0] a, fb, b, res, tgt;
    logic        pcsrc;
    if (!rst) clear_model();
    #1;
    a     = ref_fwd(bus.ForwardAE, bus.RD1E);
    fb    = ref_fwd(bus.ForwardBE, bus.RD2E);
    b     = bus.ALUSrcE ? bus.ImmExtE : fb;
    res   = ref_alu(bus.ALUControlE, a, b);
    pcsrc = (bus.BranchE && res == 0) || bus.JumpE;
    tgt   = 32'((longint'(bus.PCE) + longint'(bus.ImmExtE)) & 64'hFFFF_FFFF);
    check({tag, "_pcsrc"}, 32'(bus.PCSrcE), 32'(pcsrc));
    check({tag, "_target"}, bus.PCTargetE, tgt);
    @(posedge clk);
    if (rst) begin
      exp_reg_write  = bus.RegWriteE;
      exp_mem_write  = bus.MemWriteE;
      exp_result_src = bus.ResultSrcE;
      exp_rd         = bus.RdE;
      exp_alu        = res;
      exp_wd         = fb;
      exp_pc4        = bus.PCPlus4E;
    end else begin
      clear_model();
    end
    #1;
    check_m(tag);
  endtask

  initial begin
    clear_model();
    set_idle();

    // Reset held with busy inputs: outputs stay zero across edges.
    rst = 0;
    bus.RegWriteE = 1; bus.MemWriteE = 1; bus.ResultSrcE = 1; bus.RdE = 5'd9;
    bus.RD1E = 32'h1234; bus.RD2E = 32'h77; bus.PCPlus4E = 32'h44;
    #2;
    cycle("rst_hold");
    cycle("rst_hold2");
    check("rst_alu_zero", bus.ALUResultM, 32'd0);

    // Release between edges; first capture at the next edge.
    rst = 1;
    set_idle();
    bus.RD1E = 5; bus.RD2E = 3;
    cycle("rst_add");
    check("rst_add_const", bus.ALUResultM, 32'd8);

    // ALU sweep.
    bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 1; bus.ALUControlE = 3'b000;
    cycle("add_wrap");
    check("add_wrap_const", bus.ALUResultM, 32'd0);
    bus.RD1E = 2; bus.RD2E = 5; bus.ALUControlE = 3'b001;
    cycle("sub");
    check("sub_const", bus.ALUResultM, 32'hFFFF_FFFD);
    bus.RD1E = 32'hFFFF_FFFE; bus.RD2E = 1; bus.ALUControlE = 3'b101;
    cycle("slt");
    check("slt_const", bus.ALUResultM, 32'd1);
    bus.ALUControlE = 3'b111;
    cycle("op111");
    check("op111_const", bus.ALUResultM, 32'd0);

    // Branch taken / not taken with wrapping target.
    set_idle();
    bus.BranchE = 1; bus.RD1E = 7; bus.RD2E = 7; bus.ALUControlE = 3'b001;
    bus.PCE = 32'h100; bus.ImmExtE = 32'hFFFF_FFF0;
    #1;
    check("beq_taken_const", 32'(bus.PCSrcE), 32'd1);
    check("beq_target_const", bus.PCTargetE, 32'hF0);
    cycle("beq_taken");
    bus.RD2E = 8;
    #1;
    check("beq_not_taken_const", 32'(bus.PCSrcE), 32'd0);
    cycle("beq_not_taken");

    // Jump with link value and register write.
    set_idle();
    bus.JumpE = 1; bus.BranchE = 1; bus.RD1E = 1; bus.PCE = 32'h20; bus.ImmExtE = 32'h40;
    bus.PCPlus4E = 32'h24; bus.RegWriteE = 1; bus.RdE = 5'd1;
    #1;
    check("jal_pcsrc_const", 32'(bus.PCSrcE), 32'd1);
    check("jal_target_const", bus.PCTargetE, 32'h60);
    cycle("jal");
    check("jal_pc4_const", bus.PCPlus4M, 32'h24);
    check("jal_regwrite_const", 32'(bus.RegWriteM), 32'd1);

    // Forwarding from EX/MEM.
    set_idle();
    bus.RD1E = 32'h10;
    cycle("fwd_prod");
    bus.ForwardAE = 2'b10; bus.RD1E = 0; bus.RD2E = 1;
    cycle("fwd_a_mem");
    check("fwd_a_mem_const", bus.ALUResultM, 32'h11);

    // Asynchronous reset between edges while ALUResultM holds 0x11.
    set_idle();
    bus.BranchE = 1; bus.PCE = 32'h8; bus.ImmExtE = 32'h4;
    #2;
    rst = 0;
    #1;
    check("midrst_alu", bus.ALUResultM, 32'd0);
    check("midrst_regwrite", 32'(bus.RegWriteM), 32'd0);
    check("midrst_pc4", bus.PCPlus4M, 32'd0);
    check("midrst_pcsrc", 32'(bus.PCSrcE), 32'd1);
    check("midrst_target", bus.PCTargetE, 32'hC);
    clear_model();
    cycle("midrst_hold");
    rst = 1;

    // Store data forwarded from writeback.
    set_idle();
    bus.ForwardBE = 2'b01; bus.ResultW = 32'h55; bus.MemWriteE = 1;
    bus.ALUSrcE = 1; bus.ImmExtE = 32'h4; bus.RD1E = 32'h100;
    cycle("fwd_b_wb");
    check("fwd_b_wb_wdata_const", bus.WriteDataM, 32'h55);
    check("fwd_b_wb_memwrite_const", 32'(bus.MemWriteM), 32'd1);

    // Randomized cycles with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      bus.RegWriteE   = 1'($urandom);
      bus.ALUSrcE     = 1'($urandom);
      bus.MemWriteE   = 1'($urandom);
      bus.ResultSrcE  = 1'($urandom);
      bus.BranchE     = 1'($urandom);
      bus.JumpE       = ($urandom_range(0, 3) == 0);
      bus.ALUControlE = 3'($urandom);
      bus.RD1E        = $urandom;
      bus.RD2E        = ($urandom_range(0, 3) == 0) ? bus.RD1E : $urandom;
      bus.ImmExtE     = $urandom;
      bus.PCE         = $urandom;
      bus.PCPlus4E    = $urandom;
      bus.RdE         = 5'($urandom);
      bus.ForwardAE   = 2'($urandom);
      bus.ForwardBE   = 2'($urandom);
      bus.ResultW     = $urandom;
      rst = ($urandom_range(0, 31) != 0);
      cycle("rand");
      rst = 1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
